// File: rtl/mem_pkg.sv
// Shared constants for the data-memory responder: BEOp size/sign codes,
// FSM state encoding and the store-lane bundle used by the lane aligner.
package mem_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] BE_SW  = 3'b000;
   localparam logic [2:0] BE_SH  = 3'b001;
   localparam logic [2:0] BE_SB  = 3'b010;
   localparam logic [2:0] BE_LW  = 3'b011;
   localparam logic [2:0] BE_LHU = 3'b100;
   localparam logic [2:0] BE_LH  = 3'b101;
   localparam logic [2:0] BE_LBU = 3'b110;
   localparam logic [2:0] BE_LB  = 3'b111;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   typedef struct packed {
      logic [3:0]        mask;
      logic [DATA_W-1:0] data;
   } store_lane_t;

   function automatic logic is_store(input logic [2:0] beop);
      return (beop == BE_SW) || (beop == BE_SH) || (beop == BE_SB);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering: store mask/data replication and
// load byte/half selection with sign or zero extension.
import mem_pkg::*;

module mem_lane_align (
   input  logic [2:0]        i_beop,
   input  logic [1:0]        i_addr_lo,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rword,
   output logic [3:0]        o_mask,
   output logic [DATA_W-1:0] o_wword,
   output logic [DATA_W-1:0] o_rdata
);

   // Narrow stores replicate their data so every enabled lane already holds the right byte.
   function automatic store_lane_t store_lanes(input logic [2:0] beop, input logic [1:0] lo,
                                               input logic [DATA_W-1:0] wdata);
      store_lane_t s;
      case (beop)
         BE_SW:   begin s.mask = 4'b1111;                       s.data = wdata;              end
         BE_SH:   begin s.mask = lo[1] ? 4'b1100 : 4'b0011;     s.data = {2{wdata[15:0]}};   end
         BE_SB:   begin s.mask = 4'b0001 << lo;                 s.data = {4{wdata[7:0]}};    end
         default: begin s.mask = 4'b0000;                       s.data = wdata;              end
      endcase
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] beop, input logic [1:0] lo,
                                                     input logic [DATA_W-1:0] word);
      logic [15:0] half;
      logic [7:0]  byte_v;
      half   = lo[1] ? word[31:16] : word[15:0];
      byte_v = word[8*lo +: 8];
      case (beop)
         BE_LW:   return word;
         BE_LHU:  return {16'h0000, half};
         BE_LH:   return {{16{half[15]}}, half};
         BE_LBU:  return {24'h000000, byte_v};
         BE_LB:   return {{24{byte_v[7]}}, byte_v};
         default: return 32'h0000_0000;
      endcase
   endfunction

   store_lane_t w_st;

   assign w_st    = store_lanes(i_beop, i_addr_lo, i_wdata);
   assign o_mask  = w_st.mask;
   assign o_wword = w_st.data;
   assign o_rdata = load_extend(i_beop, i_addr_lo, i_rword);

endmodule

// File: rtl/data_mem_responder.sv
// Multicycle data-port memory responder: IDLE -> WAIT -> ACCESS with a one-cycle done pulse.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
import mem_pkg::*;

module data_mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [2:0]        beop_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              ready_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              err_o
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   localparam bit   NO_WAIT = (WAIT_CYCLES == 0);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_beop;
   logic [ADDR_W+1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_done;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W-1:0] w_idx;
   logic [DATA_W-1:0] w_rword;
   logic [3:0]        w_mask;
   logic [DATA_W-1:0] w_wword;
   logic [DATA_W-1:0] w_ldata;
   logic              w_store;
   logic              w_misalign;
   logic              w_we;
   logic              w_unused_addr;

   assign w_unused_addr = ^addr_i[31:ADDR_W+2];
   assign w_idx         = r_addr[ADDR_W+1:2];
   assign w_rword       = r_mem[w_idx];
   assign w_store       = is_store(r_beop);
   assign w_we          = !rst && (r_state == S_ACCESS) && w_store && !w_misalign;
   assign ready_o       = (r_state == S_IDLE);
   assign done_o        = r_done;
   assign rdata_o       = r_rdata;

   mem_lane_align u_align (
      .i_beop    (r_beop),
      .i_addr_lo (r_addr[1:0]),
      .i_wdata   (r_wdata),
      .i_rword   (w_rword),
      .o_mask    (w_mask),
      .o_wword   (w_wword),
      .o_rdata   (w_ldata)
   );

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_err;

   // Word ops need addr[1:0]==0, half ops need addr[0]==0.
   always_comb begin
      w_misalign = 1'b0;
      case (r_beop)
         BE_SW, BE_LW:         w_misalign = (r_addr[1:0] != 2'b00);
         BE_SH, BE_LH, BE_LHU: w_misalign = r_addr[0];
         default:              w_misalign = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (r_state == S_ACCESS) begin
         r_err <= w_misalign;
      end else begin
         r_err <= r_err;
      end
   end

   assign err_o = r_err;
`else
   assign w_misalign = 1'b0;
   assign err_o      = 1'b0;
`endif

   // Control FSM; request fields are latched at accept so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_beop  <= 3'b000;
         r_addr  <= '0;
         r_wdata <= 32'h0000_0000;
         r_done  <= 1'b0;
         r_rdata <= 32'h0000_0000;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_i) begin
                  r_beop  <= beop_i;
                  r_addr  <= addr_i[ADDR_W+1:0];
                  r_wdata <= wdata_i;
                  r_cnt   <= CNT_INIT;
                  r_state <= NO_WAIT ? S_ACCESS : S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_ACCESS;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_ACCESS: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
               if (w_misalign) begin
                  r_rdata <= 32'h0000_0000;
               end else if (!w_store) begin
                  r_rdata <= w_ldata;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Byte-enabled array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_mask[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (WAIT_CYCLES=2 and 0 instances).
import mem_pkg::*;

module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b;
   logic [2:0]  beop;
   logic [31:0] addr, wdata;
   logic        ready_a, done_a, err_a, ready_b, done_b, err_b;
   logic [31:0] rdata_a, rdata_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst), .req_i(req_a), .beop_i(beop), .addr_i(addr), .wdata_i(wdata),
      .ready_o(ready_a), .done_o(done_a), .rdata_o(rdata_a), .err_o(err_a));

   data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_nw (
      .clk(clk), .rst(rst), .req_i(req_b), .beop_i(beop), .addr_i(addr), .wdata_i(wdata),
      .ready_o(ready_b), .done_o(done_b), .rdata_o(rdata_b), .err_o(err_b));

   // Issue one request to the selected DUT and wait (bounded) for its done pulse.
   task automatic op(input bit nw, input logic [2:0] b, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output logic rdy);
      bit got;
      @(negedge clk);
      beop = b; addr = a; wdata = d;
      rdy = nw ? ready_b : ready_a;
      if (nw) req_b = 1'b1; else req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b0;
      lat = -1; rd = 32'hxxxx_xxxx; er = 1'bx; got = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (!got) begin
            @(posedge clk); #1;
            if (nw ? done_b : done_a) begin
               got = 1'b1; lat = i;
               rd = nw ? rdata_b : rdata_a;
               er = nw ? err_b : err_a;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", ready_a); end
      n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done_a); end
      n_tests++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", rdata_a); end
      n_tests++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err_a); end
      rst = 1'b0;
   endtask

   task automatic test_sw_lw();
      logic [31:0] rd; logic er, rdy; int lat;
      op(1'b0, BE_SW, 32'h10, 32'h8765_4321, rd, er, lat, rdy);
      n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL sw_ready got %b exp 1", rdy); end
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL sw_latency got %0d exp 3", lat); end
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata_kept got %h exp 0", rd); end
      op(1'b0, BE_LW, 32'h10, 32'h0, rd, er, lat, rdy);
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", lat); end
      n_tests++; if (rd !== 32'h8765_4321) begin n_fail++; $display("FAIL lw_data got %h exp 87654321", rd); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b exp 0", er); end
   endtask

   task automatic test_lane_merge();
      logic [31:0] rd; logic er, rdy; int lat;
      op(1'b0, BE_SW, 32'h20, 32'h1122_3344, rd, er, lat, rdy);
      op(1'b0, BE_SB, 32'h22, 32'hFFFF_FFAA, rd, er, lat, rdy);
      op(1'b0, BE_SH, 32'h20, 32'h1234_BEEF, rd, er, lat, rdy);
      op(1'b0, BE_LW, 32'h20, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h11AA_BEEF) begin n_fail++; $display("FAIL merge_lw got %h exp 11aabeef", rd); end
      op(1'b0, BE_LB, 32'h22, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'hFFFF_FFAA) begin n_fail++; $display("FAIL lb got %h exp ffffffaa", rd); end
      op(1'b0, BE_LBU, 32'h22, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h0000_00AA) begin n_fail++; $display("FAIL lbu got %h exp 000000aa", rd); end
      op(1'b0, BE_LH, 32'h20, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh got %h exp ffffbeef", rd); end
      op(1'b0, BE_LHU, 32'h20, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu got %h exp 0000beef", rd); end
      op(1'b0, BE_LH, 32'h22, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h0000_11AA) begin n_fail++; $display("FAIL lh_hi got %h exp 000011aa", rd); end
      op(1'b0, BE_LBU, 32'h23, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h0000_0011) begin n_fail++; $display("FAIL lbu_b3 got %h exp 00000011", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er, rdy; int lat;
      int d1, d2;
      logic rdy_wait, rdy_done;
      d1 = -1; d2 = -1; rdy_wait = 1'bx; rdy_done = 1'bx;
      @(negedge clk);
      beop = BE_SW; addr = 32'h30; wdata = 32'h0A0B_0C0D; req_a = 1'b1;
      @(posedge clk); #1;
      addr = 32'h34; wdata = 32'h5555_5555;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (i == 1) rdy_wait = ready_a;
         if (i == 4) req_a = 1'b0;
         if (done_a) begin
            if (d1 < 0) begin d1 = i; rdy_done = ready_a; end
            else if (d2 < 0) d2 = i;
         end
      end
      req_a = 1'b0;
      n_tests++; if (rdy_wait !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b exp 0", rdy_wait); end
      n_tests++; if (d1 != 3) begin n_fail++; $display("FAIL b2b_first_done got %0d exp 3", d1); end
      n_tests++; if (rdy_done !== 1'b1) begin n_fail++; $display("FAIL done_ready got %b exp 1", rdy_done); end
      n_tests++; if (d2 != 7) begin n_fail++; $display("FAIL b2b_second_done got %0d exp 7", d2); end
      op(1'b0, BE_LW, 32'h30, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h0A0B_0C0D) begin n_fail++; $display("FAIL b2b_word_a got %h exp 0a0b0c0d", rd); end
      op(1'b0, BE_LW, 32'h34, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h5555_5555) begin n_fail++; $display("FAIL b2b_word_b got %h exp 55555555", rd); end
      op(1'b1, BE_SW, 32'h08, 32'h1357_9BDF, rd, er, lat, rdy);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL nowait_sw_lat got %0d exp 1", lat); end
      op(1'b1, BE_LW, 32'h08, 32'h0, rd, er, lat, rdy);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL nowait_lw_lat got %0d exp 1", lat); end
      n_tests++; if (rd !== 32'h1357_9BDF) begin n_fail++; $display("FAIL nowait_lw got %h exp 13579bdf", rd); end
      op(1'b0, BE_LW, 32'h1010, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h8765_4321) begin n_fail++; $display("FAIL wrap_lw got %h exp 87654321", rd); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd; logic er, rdy; int lat;
      bit seen;
      op(1'b0, BE_SW, 32'h40, 32'h0102_0304, rd, er, lat, rdy);
      @(negedge clk);
      beop = BE_SW; addr = 32'h40; wdata = 32'hDEAD_BEEF; req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done_a) seen = 1'b1;
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", seen); end
      n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", ready_a); end
      op(1'b0, BE_LW, 32'h40, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL midrst_word got %h exp 01020304", rd); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; logic er, rdy; int lat;
      logic [31:0] exp_lw41, exp_word;
      logic        exp_err;
`ifdef MEM_MISALIGN_TRAP_EN
      exp_lw41 = 32'h0; exp_err = 1'b1; exp_word = 32'h0102_0304;
`else
      exp_lw41 = 32'h0102_0304; exp_err = 1'b0; exp_word = 32'h7777_0304;
`endif
      op(1'b0, BE_LW, 32'h41, 32'h0, rd, er, lat, rdy);
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL mis_lw_lat got %0d exp 3", lat); end
      n_tests++; if (rd !== exp_lw41) begin n_fail++; $display("FAIL mis_lw_data got %h exp %h", rd, exp_lw41); end
      n_tests++; if (er !== exp_err) begin n_fail++; $display("FAIL mis_lw_err got %b exp %b", er, exp_err); end
      op(1'b0, BE_SH, 32'h43, 32'h0000_7777, rd, er, lat, rdy);
      n_tests++; if (er !== exp_err) begin n_fail++; $display("FAIL mis_sh_err got %b exp %b", er, exp_err); end
      op(1'b0, BE_LW, 32'h40, 32'h0, rd, er, lat, rdy);
      n_tests++; if (rd !== exp_word) begin n_fail++; $display("FAIL mis_sh_word got %h exp %h", rd, exp_word); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL aligned_err got %b exp 0", er); end
   endtask

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
      beop = 3'b000; addr = 32'h0; wdata = 32'h0;
      test_reset();
      test_sw_lw();
      test_lane_merge();
      test_back_to_back();
      test_reset_mid_op();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
